// File: rtl/rc5_round_sched_if.sv
// Requester, subkey-store and result-consumer signals of the RC5 round scheduler.
// master is the surrounding system; slave is the scheduler itself.
interface rc5_round_sched_if #(
  parameter int IDX_W = 4
);
  logic             enc_req;
  logic [63:0]      enc_din;
  logic             enc_ack;
  logic             dec_req;
  logic [63:0]      dec_din;
  logic             dec_ack;
  logic [IDX_W-1:0] skey_idx;
  logic [31:0]      skey_even;
  logic [31:0]      skey_odd;
  logic [63:0]      dout;
  logic             dout_vld;
  logic             dout_dec;
  logic             dout_rdy;
  logic             busy;

  modport master (
    output enc_req, enc_din, dec_req, dec_din,
    output skey_even, skey_odd, dout_rdy,
    input  enc_ack, dec_ack, skey_idx,
    input  dout, dout_vld, dout_dec, busy
  );

  modport slave (
    input  enc_req, enc_din, dec_req, dec_din,
    input  skey_even, skey_odd, dout_rdy,
    output enc_ack, dec_ack, skey_idx,
    output dout, dout_vld, dout_dec, busy
  );
endinterface

// File: rtl/rc5_round_sched.sv
// RC5-32 round scheduler: one iterative round engine shared by an
// encrypt and a decrypt requester, round-robin arbitrated.
module rc5_round_sched #(
  parameter int ROUNDS = 12,
  parameter int IDX_W  = 4
) (
  input logic              clk,
  input logic              clr,
  rc5_round_sched_if.slave io
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ROUND,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] I_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             mode_q, mode_d;
  logic             last_q, last_d;
  logic [63:0]      dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             dec_q, dec_d;
  logic [IDX_W-1:0] idx;

  logic        grant_enc, grant_dec;
  logic [63:0] din;
  logic [31:0] ea, eb, da, db, pa, pb;

  // {x,x} shifted keeps rotate-by-0 an identity without a 32-bit shift
  function automatic logic [31:0] rotl(
    input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // last_q=1 means decrypt was granted last, so encrypt wins a tie
  assign grant_enc = (state_q == S_IDLE) && io.enc_req
                   && (!io.dec_req || last_q);
  assign grant_dec = (state_q == S_IDLE) && io.dec_req
                   && !grant_enc;
  assign din = grant_dec ? io.dec_din : io.enc_din;

  assign ea = rotl(a_q ^ b_q, b_q[4:0]) + io.skey_even;
  assign eb = rotl(b_q ^ ea, ea[4:0]) + io.skey_odd;
  assign db = rotr(b_q - io.skey_odd, a_q[4:0]) ^ a_q;
  assign da = rotr(a_q - io.skey_even, db[4:0]) ^ db;
  assign pa = a_q - io.skey_even;
  assign pb = b_q - io.skey_odd;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    mode_d  = mode_q;
    last_d  = last_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    dec_d   = dec_q;
    idx     = '0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          grant_enc, grant_dec: begin
            a_d     = din[63:32];
            b_d     = din[31:0];
            mode_d  = grant_dec;
            last_d  = grant_dec;
            state_d = S_PRE;
          end
          default: ;
        endcase
      end
      S_PRE: begin
        if (!mode_q) begin
          a_d = a_q + io.skey_even;
          b_d = b_q + io.skey_odd;
          i_d = I_ONE;
        end else begin
          i_d = I_LAST;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        idx = i_q;
        if (!mode_q) begin
          a_d = ea;
          b_d = eb;
          i_d = i_q + I_ONE;
          if (i_q == I_LAST) begin
            i_d     = '0;
            dout_d  = {ea, eb};
            vld_d   = 1'b1;
            dec_d   = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          a_d = da;
          b_d = db;
          i_d = i_q - I_ONE;
          if (i_q == I_ONE) state_d = S_POST;
        end
      end
      S_POST: begin
        a_d     = pa;
        b_d     = pb;
        dout_d  = {pa, pb};
        vld_d   = 1'b1;
        dec_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.dout_rdy) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b1;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      dec_q   <= dec_d;
    end
  end

  assign io.enc_ack  = grant_enc;
  assign io.dec_ack  = grant_dec;
  assign io.skey_idx = idx;
  assign io.dout     = dout_q;
  assign io.dout_vld = vld_q;
  assign io.dout_dec = dec_q;
  assign io.busy     = (state_q != S_IDLE);
endmodule
